// File: rtl/reg_exec_if.sv
// Instruction handshake plus register-file port bundle between a producer/file and reg_exec_ctrl.
interface reg_exec_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 4,
    parameter int OPC_W  = 4
);
    localparam int INSTR_W = OPC_W + 3 * AW;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [AW-1:0]      ra1;
    logic [AW-1:0]      ra2;
    logic [AW-1:0]      wa3;
    logic [DATA_W-1:0]  wd3;
    logic               we3;
    logic               flag_z;
    logic               flag_c;
    logic               done;
    logic               illegal;

    // master: instruction producer together with the register file it fronts
    modport master (
        output instr_valid, instr, rd1, rd2,
        input  instr_ready, ra1, ra2, wa3, wd3, we3, flag_z, flag_c, done, illegal
    );

    modport slave (
        input  instr_valid, instr, rd1, rd2,
        output instr_ready, ra1, ra2, wa3, wd3, we3, flag_z, flag_c, done, illegal
    );
endinterface

// File: rtl/reg_exec_ctrl.sv
// Three-cycle execute controller (IDLE -> EXEC -> WB) driving a 16x8 register file.
// Optional feature macro: EXEC_MUL_EN adds opcode B = MUL; otherwise opcode B is illegal.
module reg_exec_ctrl #(
    parameter int DATA_W = 8,
    parameter int AW     = 4,
    parameter int OPC_W  = 4
) (
    input  logic     clk,
    input  logic     rst,
    reg_exec_if.slave bus
);
    localparam int INSTR_W = OPC_W + 3 * AW;

    localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_MOV = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_CMP = OPC_W'(10);
`ifdef EXEC_MUL_EN
    localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(11);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [INSTR_W-1:0] instr_reg;
    logic [AW-1:0]      ra1_reg;
    logic [AW-1:0]      ra2_reg;
    logic [AW-1:0]      wa3_reg;
    logic [DATA_W-1:0]  wd3_reg;
    logic               we3_reg;
    logic               done_reg;
    logic               illegal_reg;
    logic               flag_z_reg;
    logic               flag_c_reg;

    logic [OPC_W-1:0]   opcode;
    logic [AW-1:0]      rd_field;
    logic [DATA_W-1:0]  imm;
    logic               accept;

    logic [DATA_W:0]    sum_full;
    logic [DATA_W:0]    diff_full;
    logic [DATA_W-1:0]  alu_r;
    logic               alu_c;
    logic               alu_upd;
    logic               alu_wr;
    logic               alu_ill;

    assign opcode   = instr_reg[INSTR_W-1 -: OPC_W];
    assign rd_field = instr_reg[3*AW-1 -: AW];
    assign imm      = instr_reg[DATA_W-1:0];

    // Ready is gated by rst so it reads low throughout reset even once state is IDLE.
    assign bus.instr_ready = (state_reg == IDLE) && !rst;
    assign accept          = (state_reg == IDLE) && bus.instr_valid;

    assign bus.ra1     = ra1_reg;
    assign bus.ra2     = ra2_reg;
    assign bus.wa3     = wa3_reg;
    assign bus.wd3     = wd3_reg;
    assign bus.we3     = we3_reg;
    assign bus.done    = done_reg;
    assign bus.illegal = illegal_reg;
    assign bus.flag_z  = flag_z_reg;
    assign bus.flag_c  = flag_c_reg;

    // Top bit of the difference is the borrow (A < B).
    assign sum_full  = {1'b0, bus.rd1} + {1'b0, bus.rd2};
    assign diff_full = {1'b0, bus.rd1} - {1'b0, bus.rd2};

`ifdef EXEC_MUL_EN
    logic [2*DATA_W-1:0] mul_full;
    assign mul_full = {{DATA_W{1'b0}}, bus.rd1} * {{DATA_W{1'b0}}, bus.rd2};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.instr_valid) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_upd = 1'b0;
        alu_wr  = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                alu_r = sum_full[DATA_W-1:0]; alu_c = sum_full[DATA_W];
                alu_upd = 1'b1; alu_wr = 1'b1;
            end
            OP_SUB: begin
                alu_r = diff_full[DATA_W-1:0]; alu_c = diff_full[DATA_W];
                alu_upd = 1'b1; alu_wr = 1'b1;
            end
            OP_AND: begin alu_r = bus.rd1 & bus.rd2; alu_upd = 1'b1; alu_wr = 1'b1; end
            OP_OR:  begin alu_r = bus.rd1 | bus.rd2; alu_upd = 1'b1; alu_wr = 1'b1; end
            OP_XOR: begin alu_r = bus.rd1 ^ bus.rd2; alu_upd = 1'b1; alu_wr = 1'b1; end
            OP_MOV: begin alu_r = bus.rd1;           alu_upd = 1'b1; alu_wr = 1'b1; end
            OP_LDI: begin alu_r = imm;               alu_upd = 1'b1; alu_wr = 1'b1; end
            OP_SHL: begin
                alu_r = {bus.rd1[DATA_W-2:0], 1'b0}; alu_c = bus.rd1[DATA_W-1];
                alu_upd = 1'b1; alu_wr = 1'b1;
            end
            OP_SHR: begin
                alu_r = {1'b0, bus.rd1[DATA_W-1:1]}; alu_c = bus.rd1[0];
                alu_upd = 1'b1; alu_wr = 1'b1;
            end
            OP_CMP: begin
                alu_r = diff_full[DATA_W-1:0]; alu_c = diff_full[DATA_W];
                alu_upd = 1'b1;
            end
`ifdef EXEC_MUL_EN
            OP_MUL: begin
                alu_r = mul_full[DATA_W-1:0]; alu_c = |mul_full[2*DATA_W-1:DATA_W];
                alu_upd = 1'b1; alu_wr = 1'b1;
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    // Read addresses are loaded at the accept edge so they are valid for the whole EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_reg   <= '0;
            ra1_reg     <= '0;
            ra2_reg     <= '0;
            wa3_reg     <= '0;
            wd3_reg     <= '0;
            we3_reg     <= 1'b0;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            flag_z_reg  <= 1'b0;
            flag_c_reg  <= 1'b0;
        end else begin
            we3_reg     <= 1'b0;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            if (accept) begin
                instr_reg <= bus.instr;
                ra1_reg   <= bus.instr[2*AW-1 -: AW];
                ra2_reg   <= bus.instr[AW-1:0];
            end
            if (state_reg == EXEC) begin
                wa3_reg     <= rd_field;
                wd3_reg     <= alu_r;
                we3_reg     <= alu_wr;
                done_reg    <= 1'b1;
                illegal_reg <= alu_ill;
                if (alu_upd) begin
                    flag_z_reg <= (alu_r == '0);
                    flag_c_reg <= alu_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_exec_ctrl.sv
// Directed-vector bench for reg_exec_ctrl with a behavioural 16x8 register file on the bus.
module tb_reg_exec_ctrl;
    logic clk;
    logic rst;
    logic clear_rf;
    int   vectors;
    int   miscompares;

    logic [7:0] rf [16];

    logic       ex_ready, ex_we;
    logic       wb_we, wb_done, wb_ill, wb_z, wb_c;
    logic [3:0] wb_wa;
    logic [7:0] wb_wd;
    logic       id_we, id_done, id_ready;
    logic       fire;

    reg_exec_if bus ();

    reg_exec_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: combinational reads, write at the clock edge, no reset of contents.
    assign bus.rd1 = rf[bus.ra1];
    assign bus.rd2 = rf[bus.ra2];

    always @(posedge clk) begin
        if (clear_rf) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (bus.we3) begin
            rf[bus.wa3] <= bus.wd3;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at a falling edge with the controller in IDLE; returns at a falling edge in IDLE.
    task automatic do_op(input logic [15:0] ins);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        ex_ready = bus.instr_ready;
        ex_we    = bus.we3;
        @(negedge clk);
        wb_we   = bus.we3;
        wb_wa   = bus.wa3;
        wb_wd   = bus.wd3;
        wb_done = bus.done;
        wb_ill  = bus.illegal;
        wb_z    = bus.flag_z;
        wb_c    = bus.flag_c;
        @(negedge clk);
        id_we    = bus.we3;
        id_done  = bus.done;
        id_ready = bus.instr_ready;
        $display("op %04h: we3=%0d wa3=%0d wd3=%02h done=%0d illegal=%0d z=%0d c=%0d",
                 ins, wb_we, wb_wa, wb_wd, wb_done, wb_ill, wb_z, wb_c);
    endtask

    task automatic expect_wb(input string tag, input logic we, input logic [3:0] wa,
                             input logic [7:0] wd, input logic ill, input logic z, input logic c);
        check({tag, "_we3"}, 16'(wb_we), 16'(we));
        if (we) begin
            check({tag, "_wa3"}, 16'(wb_wa), 16'(wa));
            check({tag, "_wd3"}, 16'(wb_wd), 16'(wd));
        end
        check({tag, "_done"}, 16'(wb_done), 16'd1);
        check({tag, "_illegal"}, 16'(wb_ill), 16'(ill));
        check({tag, "_z"}, 16'(wb_z), 16'(z));
        check({tag, "_c"}, 16'(wb_c), 16'(c));
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        rst             = 1'b1;
        clear_rf        = 1'b1;
        @(negedge clk);
        clear_rf = 1'b0;
        @(negedge clk);
        check("rst_ready", 16'(bus.instr_ready), 16'd0);
        check("rst_we3", 16'(bus.we3), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_illegal", 16'(bus.illegal), 16'd0);
        check("rst_flags", {14'd0, bus.flag_z, bus.flag_c}, 16'd0);
        check("rst_wa3", 16'(bus.wa3), 16'd0);
        check("rst_wd3", 16'(bus.wd3), 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 16'(bus.instr_ready), 16'd1);

        do_op(16'h713C);
        check("ldi_exec_ready", 16'(ex_ready), 16'd0);
        check("ldi_exec_we3", 16'(ex_we), 16'd0);
        expect_wb("ldi", 1'b1, 4'd1, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("ldi_idle_we3", 16'(id_we), 16'd0);
        check("ldi_idle_done", 16'(id_done), 16'd0);
        check("ldi_idle_ready", 16'(id_ready), 16'd1);
        check("ldi_rf1", 16'(rf[1]), 16'h003C);

        do_op(16'h71F0);
        do_op(16'h7220);
        do_op(16'h1312);
        expect_wb("add", 1'b1, 4'd3, 8'h10, 1'b0, 1'b0, 1'b1);
        do_op(16'h2421);
        expect_wb("sub", 1'b1, 4'd4, 8'h30, 1'b0, 1'b0, 1'b1);
        do_op(16'hA011);
        expect_wb("cmp", 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("cmp_rf0", 16'(rf[0]), 16'h0000);
        do_op(16'hE123);
        expect_wb("illE", 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("illE_rf1", 16'(rf[1]), 16'h00F0);
        do_op(16'h5912);
        expect_wb("xor", 1'b1, 4'd9, 8'hD0, 1'b0, 1'b0, 1'b0);
        do_op(16'h8B10);
        expect_wb("shl", 1'b1, 4'd11, 8'hE0, 1'b0, 1'b0, 1'b1);
        do_op(16'h9A20);
        expect_wb("shr", 1'b1, 4'd10, 8'h10, 1'b0, 1'b0, 1'b0);

        // Valid held for six cycles: LDI r5 then MOV r6,r5 accepted three cycles apart.
        bus.instr       = 16'h75A5;
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("b2b_ready", 16'(bus.instr_ready), 16'((c % 3) == 0));
            fire = bus.instr_ready;
            @(posedge clk);
            @(negedge clk);
            if (fire) bus.instr = 16'h6650;
        end
        bus.instr_valid = 1'b0;
        $display("b2b: wa3=%0d wd3=%02h rf5=%02h rf6=%02h", bus.wa3, bus.wd3, rf[5], rf[6]);
        check("b2b_rf5", 16'(rf[5]), 16'h00A5);
        check("b2b_rf6", 16'(rf[6]), 16'h00A5);
        check("b2b_wa3", 16'(bus.wa3), 16'd6);
        check("b2b_wd3", 16'(bus.wd3), 16'h00A5);

        // Reset during EXEC of an ADD: nothing written, flags cleared.
        do_op(16'h1712);
        expect_wb("add7", 1'b1, 4'd7, 8'h10, 1'b0, 1'b0, 1'b1);
        bus.instr       = 16'h1812;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_we3", 16'(bus.we3), 16'd0);
        check("midrst_done", 16'(bus.done), 16'd0);
        check("midrst_flags", {14'd0, bus.flag_z, bus.flag_c}, 16'd0);
        check("midrst_ready", 16'(bus.instr_ready), 16'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 16'(bus.instr_ready), 16'd1);
        @(negedge clk);
        check("midrst_we3_after", 16'(bus.we3), 16'd0);
        check("midrst_rf8", 16'(rf[8]), 16'h0000);
        $display("midrst: we3=%0d flags=%0d%0d rf8=%02h", bus.we3, bus.flag_z, bus.flag_c, rf[8]);

        do_op(16'h1111);
        expect_wb("add_self", 1'b1, 4'd1, 8'hE0, 1'b0, 1'b0, 1'b1);
        check("add_self_rf1", 16'(rf[1]), 16'h00E0);

        do_op(16'h7C10);
        do_op(16'h7D11);
        do_op(16'hBECD);
`ifdef EXEC_MUL_EN
        expect_wb("mul", 1'b1, 4'd14, 8'h10, 1'b0, 1'b0, 1'b1);
        check("mul_rf14", 16'(rf[14]), 16'h0010);
`else
        expect_wb("illB", 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("illB_rf14", 16'(rf[14]), 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
